stereo_ms: RTL

STEREO_MS -- requirements
Module: stereo_ms

---
 rtl/stereo_ms.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stereo_ms.sv
// Mid/side to left/right stereo reconstruction over one granule held in two dual-port RAMs.
// Define STEREO_MS_SATURATE_EN to clamp out-of-range results instead of wrapping them.
module stereo_ms #(
  parameter int GRANULE_LEN = 576,
  parameter int DATA_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  output logic [9:0]        granule_ch0_read_addr,
  input  logic [DATA_W-1:0] granule_ch0_read_data,
  output logic              granule_ch0_write_enable,
  output logic [9:0]        granule_ch0_write_addr,
  output logic [DATA_W-1:0] granule_ch0_write_data,
  output logic [9:0]        granule_ch1_read_addr,
  input  logic [DATA_W-1:0] granule_ch1_read_data,
  output logic              granule_ch1_write_enable,
  output logic [9:0]        granule_ch1_write_addr,
  output logic [DATA_W-1:0] granule_ch1_write_data,
  input  logic [1:0]        header_mode,
  input  logic [1:0]        header_mode_extension,
  input  logic              stage_ready,
  output logic              stage_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [9:0]        LAST_ADDR = 10'(GRANULE_LEN - 1);
  localparam int                SW        = DATA_W + 1;   // sum/difference width
  localparam int                PW        = SW + 18;      // full product width
  localparam int                RW        = PW - 17;      // width after the Q1.17 shift
  localparam logic signed [17:0] COEF     = 18'sd92682;   // 1/sqrt(2) in Q1.17

  state_e                   state_q, state_d;
  logic [9:0]               rd_addr_q, rd_addr_d;
  logic                     dv_q;
  logic [9:0]               dv_addr_q;
  logic                     wr_en_q;
  logic [9:0]               wr_addr_q;
  logic [DATA_W-1:0]        wr0_q, wr1_q;

  logic                     active;
  logic                     unused_ext0;
  logic signed [DATA_W-1:0] mid, side;
  logic signed [SW-1:0]     sum_w, diff_w;
  logic signed [PW-1:0]     rnd_l, rnd_r;
  logic signed [RW-1:0]     res_l, res_r;

  assign active      = (header_mode == 2'b01) && header_mode_extension[1];
  assign unused_ext0 = header_mode_extension[0];

  function automatic logic [DATA_W-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef STEREO_MS_SATURATE_EN
    localparam logic signed [RW-1:0] MAX_V = RW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_V = RW'(-(2 ** (DATA_W - 1)));
    if (v > MAX_V)      return DATA_W'(MAX_V);
    else if (v < MIN_V) return DATA_W'(MIN_V);
    else                return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  // Rounded (M +/- S) * C / 2^17; arithmetic shift floors, the +2^16 bias makes it round-half-up.
  always_comb begin
    mid    = $signed(granule_ch0_read_data);
    side   = $signed(granule_ch1_read_data);
    sum_w  = SW'(mid) + SW'(side);
    diff_w = SW'(mid) - SW'(side);
    rnd_l  = PW'(sum_w)  * PW'(COEF) + PW'(65536);
    rnd_r  = PW'(diff_w) * PW'(COEF) + PW'(65536);
    res_l  = RW'(rnd_l >>> 17);
    res_r  = RW'(rnd_r >>> 17);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      IDLE: begin
        if (stage_ready) begin
          if (active) begin
            state_d   = RUN;
            rd_addr_d = '0;
          end else begin
            state_d   = DONE;
          end
        end
      end
      RUN: begin
        if (rd_addr_q == LAST_ADDR) state_d   = DRAIN;
        else                        rd_addr_d = rd_addr_q + 10'd1;
      end
      DRAIN: begin
        if (wr_en_q && (wr_addr_q == LAST_ADDR)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      dv_q      <= 1'b0;
      dv_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr0_q     <= '0;
      wr1_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      dv_q      <= (state_q == RUN);
      dv_addr_q <= rd_addr_q;
      wr_en_q   <= dv_q;
      if (dv_q) begin
        wr_addr_q <= dv_addr_q;
        wr0_q     <= reduce(res_l);
        wr1_q     <= reduce(res_r);
      end
    end
  end

  assign granule_ch0_read_addr    = rd_addr_q;
  assign granule_ch1_read_addr    = rd_addr_q;
  assign granule_ch0_write_enable = wr_en_q;
  assign granule_ch1_write_enable = wr_en_q;
  assign granule_ch0_write_addr   = wr_addr_q;
  assign granule_ch1_write_addr   = wr_addr_q;
  assign granule_ch0_write_data   = wr0_q;
  assign granule_ch1_write_data   = wr1_q;
  assign stage_done               = (state_q == DONE);

endmodule
